// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment pattern-set select controller.
// Holds the FSM state encoding, the select width and the default timing
// constants (50 MHz board clock).
package display_pkg;

  localparam int unsigned SEL_W               = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms at 50 MHz
  localparam int unsigned DEF_AUTO_PERIOD     = 50_000_000; // 1 s at 50 MHz

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_e;

endpackage

// File: rtl/key_debounce.sv
// Single pushbutton front end: 2-flop synchroniser, stability counter,
// debounced level and a one-cycle press strobe on a debounced 1->0 edge.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   key_n     - raw active-low button, asynchronous to clk
//   press     - registered one-cycle pulse per debounced press
module key_debounce
  import display_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Count cycles of disagreement; adopt the new level after a full window.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/display_select_ctrl.sv
// Upstream controller for the three-digit 7-segment pattern decoder.
// Debounces three buttons and steps the 2-bit pattern-set select either
// manually (next/prev) or automatically every AUTO_PERIOD cycles.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   key_next_n/prev_n   - raw active-low step buttons
//   key_mode_n          - raw active-low MANUAL/AUTO toggle button
//   select              - registered pattern-set code
//   auto_active         - registered, high in AUTO state
//   step_pulse          - one-cycle strobe in the first cycle of a new select
module display_select_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned AUTO_PERIOD     = DEF_AUTO_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_next_n,
  input  logic             key_prev_n,
  input  logic             key_mode_n,
  output logic [SEL_W-1:0] select,
  output logic             auto_active,
  output logic             step_pulse
);

  localparam int unsigned TMR_W = $clog2(AUTO_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_PERIOD - 1);

  logic press_next, press_prev, press_mode;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .rst(rst), .key_n(key_next_n), .press(press_next)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk(clk), .rst(rst), .key_n(key_prev_n), .press(press_prev)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .rst(rst), .key_n(key_mode_n), .press(press_mode)
  );

  state_e           state_q,       state_d;
  logic [TMR_W-1:0] timer_q,       timer_d;
  logic [SEL_W-1:0] select_q,      select_d;
  logic             auto_active_q, auto_active_d;
  logic             step_pulse_q,  step_pulse_d;
  logic             any_step;
  logic             tick;

  // Next-state: manual steps win over the auto tick, mode toggle wins over
  // the auto tick, and a mode toggle still applies a simultaneous step.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    select_d = select_q;
    any_step = press_next | press_prev;
    tick     = (state_q == ST_AUTO) && (timer_q == TMR_LAST);

    if (state_q == ST_AUTO) begin
      timer_d = tick ? '0 : timer_q + TMR_W'(1);
    end

    if (press_next && !press_prev) begin
      select_d = select_q + SEL_W'(1);
    end else if (press_prev && !press_next) begin
      select_d = select_q - SEL_W'(1);
    end else if (tick && !any_step && !press_mode) begin
      select_d = select_q + SEL_W'(1);
    end

    if (any_step && (state_q == ST_AUTO)) begin
      timer_d = '0;
    end

    if (press_mode) begin
      state_d = (state_q == ST_AUTO) ? ST_MANUAL : ST_AUTO;
      timer_d = '0;
    end

    auto_active_d = (state_d == ST_AUTO);
    step_pulse_d  = (select_d != select_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_MANUAL;
      timer_q       <= '0;
      select_q      <= '0;
      auto_active_q <= 1'b0;
      step_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      select_q      <= select_d;
      auto_active_q <= auto_active_d;
      step_pulse_q  <= step_pulse_d;
    end
  end

  assign select      = select_q;
  assign auto_active = auto_active_q;
  assign step_pulse  = step_pulse_q;

endmodule

// File: tb/tb_display_select_ctrl.sv
// Directed bench for display_select_ctrl with DEBOUNCE_CYCLES=4, AUTO_PERIOD=10.
// Inputs change and outputs are sampled on the falling edge.
// Timing: a key driven low before rising edge 1 yields new select after edge 7.
module tb_display_select_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] keys_n;   // [0]=next, [1]=prev, [2]=mode
  logic [1:0] select;
  logic       auto_active;
  logic       step_pulse;

  int n_cmp;
  int n_mis;
  int pulse_cnt;
  int p0;

  display_select_ctrl #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_next_n (keys_n[0]),
    .key_prev_n (keys_n[1]),
    .key_mode_n (keys_n[2]),
    .select     (select),
    .auto_active(auto_active),
    .step_pulse (step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n falling edges, counting step_pulse cycles.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (step_pulse === 1'b1) pulse_cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // Clean press: low long enough to debounce, then released and settled.
  task automatic pulse_key(input int k);
    keys_n[k] = 1'b0;
    step(8);
    keys_n[k] = 1'b1;
    step(8);
  endtask

  task automatic test_reset();
    step(3);
    n_cmp++; if (select !== 2'b00) begin n_mis++; $display("FAIL reset_select: got %b want 00", select); end
    n_cmp++; if (auto_active !== 1'b0) begin n_mis++; $display("FAIL reset_auto: got %b want 0", auto_active); end
    n_cmp++; if (step_pulse !== 1'b0) begin n_mis++; $display("FAIL reset_step: got %b want 0", step_pulse); end
    rst = 1'b0;
    p0 = pulse_cnt;
    step(50);
    n_cmp++; if (select !== 2'b00) begin n_mis++; $display("FAIL idle_select: got %b want 00", select); end
    n_cmp++; if (pulse_cnt - p0 != 0) begin n_mis++; $display("FAIL idle_pulses: got %0d want 0", pulse_cnt - p0); end
  endtask

  task automatic test_glitch();
    p0 = pulse_cnt;
    keys_n[0] = 1'b0;
    step(3);
    keys_n[0] = 1'b1;
    step(12);
    n_cmp++; if (select !== 2'b00) begin n_mis++; $display("FAIL glitch_select: got %b want 00", select); end
    n_cmp++; if (pulse_cnt - p0 != 0) begin n_mis++; $display("FAIL glitch_pulses: got %0d want 0", pulse_cnt - p0); end
  endtask

  task automatic test_single_press();
    p0 = pulse_cnt;
    keys_n[0] = 1'b0;
    step(6);
    n_cmp++; if (select !== 2'b00) begin n_mis++; $display("FAIL press_early: got %b want 00", select); end
    step(1);
    n_cmp++; if (select !== 2'b01) begin n_mis++; $display("FAIL press_select: got %b want 01", select); end
    n_cmp++; if (step_pulse !== 1'b1) begin n_mis++; $display("FAIL press_pulse: got %b want 1", step_pulse); end
    step(1);
    n_cmp++; if (step_pulse !== 1'b0) begin n_mis++; $display("FAIL press_pulse_len: got %b want 0", step_pulse); end
    step(100);
    n_cmp++; if (select !== 2'b01) begin n_mis++; $display("FAIL hold_select: got %b want 01", select); end
    n_cmp++; if (pulse_cnt - p0 != 1) begin n_mis++; $display("FAIL hold_pulses: got %0d want 1", pulse_cnt - p0); end
    keys_n[0] = 1'b1;
    step(10);
    n_cmp++; if (select !== 2'b01) begin n_mis++; $display("FAIL release_select: got %b want 01", select); end
  endtask

  task automatic test_next_prev_wrap();
    logic [1:0] exp_sel;
    do_reset();
    p0 = pulse_cnt;
    exp_sel = 2'b00;
    for (int i = 0; i < 4; i++) begin
      pulse_key(0);
      exp_sel = exp_sel + 2'b01;
      n_cmp++; if (select !== exp_sel) begin n_mis++; $display("FAIL next_%0d: got %b want %b", i, select, exp_sel); end
    end
    pulse_key(1);
    n_cmp++; if (select !== 2'b11) begin n_mis++; $display("FAIL prev_wrap: got %b want 11", select); end
    n_cmp++; if (pulse_cnt - p0 != 5) begin n_mis++; $display("FAIL wrap_pulses: got %0d want 5", pulse_cnt - p0); end
  endtask

  task automatic test_simultaneous();
    p0 = pulse_cnt;
    keys_n[1:0] = 2'b00;
    step(8);
    keys_n[1:0] = 2'b11;
    step(8);
    n_cmp++; if (select !== 2'b11) begin n_mis++; $display("FAIL simul_select: got %b want 11", select); end
    n_cmp++; if (pulse_cnt - p0 != 0) begin n_mis++; $display("FAIL simul_pulses: got %0d want 0", pulse_cnt - p0); end
  endtask

  task automatic test_auto();
    logic [1:0] exp_sel;
    do_reset();
    keys_n[2] = 1'b0;
    step(7);                                // after edge 7: AUTO, timer 0
    n_cmp++; if (auto_active !== 1'b1) begin n_mis++; $display("FAIL auto_enter: got %b want 1", auto_active); end
    step(1);
    keys_n[2] = 1'b1;
    step(8);                                // after edge 16
    n_cmp++; if (select !== 2'b00) begin n_mis++; $display("FAIL auto_before_tick: got %b want 00", select); end
    step(1);                                // after edge 17: first tick
    n_cmp++; if (select !== 2'b01) begin n_mis++; $display("FAIL auto_tick1: got %b want 01", select); end
    n_cmp++; if (step_pulse !== 1'b1) begin n_mis++; $display("FAIL auto_tick1_pulse: got %b want 1", step_pulse); end
    exp_sel = 2'b01;
    for (int i = 0; i < 4; i++) begin       // edges 27, 37, 47, 57
      step(10);
      exp_sel = exp_sel + 2'b01;
      n_cmp++; if (select !== exp_sel) begin n_mis++; $display("FAIL auto_tick_%0d: got %b want %b", i + 2, select, exp_sel); end
    end
    step(3);                                // after edge 60
    keys_n[2] = 1'b0;                       // mode event lands on the edge-67 tick
    step(6);
    n_cmp++; if (auto_active !== 1'b1) begin n_mis++; $display("FAIL auto_hold: got %b want 1", auto_active); end
    step(1);
    n_cmp++; if (auto_active !== 1'b0) begin n_mis++; $display("FAIL auto_exit: got %b want 0", auto_active); end
    n_cmp++; if (select !== 2'b01) begin n_mis++; $display("FAIL auto_exit_select: got %b want 01", select); end
    n_cmp++; if (step_pulse !== 1'b0) begin n_mis++; $display("FAIL auto_exit_pulse: got %b want 0", step_pulse); end
    keys_n[2] = 1'b1;
    step(20);
    n_cmp++; if (select !== 2'b01) begin n_mis++; $display("FAIL manual_after_auto: got %b want 01", select); end
  endtask

  task automatic test_auto_next_and_reset();
    do_reset();
    keys_n[2] = 1'b0;
    step(7);
    n_cmp++; if (auto_active !== 1'b1) begin n_mis++; $display("FAIL an_enter: got %b want 1", auto_active); end
    step(1);                                // after edge 8
    keys_n[2] = 1'b1;
    keys_n[0] = 1'b0;                       // next event processed at edge 15 (timer=7)
    step(6);
    n_cmp++; if (select !== 2'b00) begin n_mis++; $display("FAIL an_before: got %b want 00", select); end
    step(1);
    n_cmp++; if (select !== 2'b01) begin n_mis++; $display("FAIL an_step: got %b want 01", select); end
    n_cmp++; if (step_pulse !== 1'b1) begin n_mis++; $display("FAIL an_step_pulse: got %b want 1", step_pulse); end
    step(1);
    keys_n[0] = 1'b1;
    step(1);                                // after edge 17: old tick time
    n_cmp++; if (select !== 2'b01) begin n_mis++; $display("FAIL an_old_tick: got %b want 01", select); end
    step(7);                                // after edge 24
    n_cmp++; if (select !== 2'b01) begin n_mis++; $display("FAIL an_pre_tick: got %b want 01", select); end
    step(1);                                // after edge 25
    n_cmp++; if (select !== 2'b10) begin n_mis++; $display("FAIL an_tick: got %b want 10", select); end
    rst = 1'b1;
    step(1);
    n_cmp++; if (select !== 2'b00) begin n_mis++; $display("FAIL rst_auto_select: got %b want 00", select); end
    n_cmp++; if (auto_active !== 1'b0) begin n_mis++; $display("FAIL rst_auto_active: got %b want 0", auto_active); end
    rst = 1'b0;
    step(15);
    n_cmp++; if (select !== 2'b00) begin n_mis++; $display("FAIL rst_auto_idle: got %b want 00", select); end
  endtask

  initial begin
    rst       = 1'b1;
    keys_n    = 3'b111;
    n_cmp     = 0;
    n_mis     = 0;
    pulse_cnt = 0;
    p0        = 0;
    test_reset();
    test_glitch();
    test_single_press();
    test_next_prev_wrap();
    test_simultaneous();
    test_auto();
    test_auto_next_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
